fetch_align: RTL
================

FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL have parameter QDEPTH, default 8, byte capacity of the alignment queue (even, >=6).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port imem_req, output, 1, word read request this cycle.
REQ-005 SHALL have port imem_addr, output, 16, byte address of the requested word.
REQ-006 SHALL have port imem_rdata, input, 16, word returned exactly one cycle after imem_req: [15:8] is byte at addr, [7:0] is byte at addr+1.
REQ-007 SHALL have port redirect, input, 1, flush-and-refetch strobe (taken jump/call/ret/rst/pchl).
REQ-008 SHALL have port redirect_pc, input, 16, new fetch address, valid with redirect.
REQ-009 SHALL have port dec_valid, output, 1, a complete instruction is presented to decode.
REQ-010 SHALL have port dec_ready, input, 1, decode accepts the presented instruction.
REQ-011 SHALL have port dec_instr, output, 24, {opcode, byte2, byte3}; unused trailing bytes are 8'h00.
REQ-012 SHALL have port dec_len, output, 2, instruction length 1, 2 or 3.
REQ-013 SHALL have port dec_pc, output, 16, address of the opcode byte.

Function
REQ-014 SHALL keep a circular byte queue (head, tail, count), a 16-bit fetch address and a 16-bit head pc.
REQ-015 SHALL assert imem_req with imem_addr = fetch address when count + 2*inflight + 2 <= QDEPTH and redirect is low; fetch address += 2 per request, wrapping FFFF->0000 modulo 2^16.
REQ-016 SHALL push both returned bytes (addr byte first) at the edge ending the return cycle, unless that response was flushed.
REQ-017 SHALL length-decode the head byte: 3 bytes = 00rp0001, 22, 2A, 32, 3A, C3, 11ccc010, CD, 11ccc100; 2 bytes = 00ddd110, C6, CE, D6, DE, E6, EE, F6, FE, D3, DB; all others 1.
REQ-018 SHALL assert dec_valid combinationally iff count >= dec_len and not in the cycle after redirect.
REQ-019 SHALL transfer on dec_valid && dec_ready: pop dec_len bytes, advance head pc by dec_len (mod 2^16); push and pop in the same cycle allowed, count updated by net amount.
REQ-020 SHALL hold dec_instr/dec_len/dec_pc stable while dec_valid && !dec_ready.
REQ-021 SHALL on redirect: empty queue, set fetch address and head pc to redirect_pc, discard any response arriving next cycle; redirect wins over a simultaneous transfer or push.
REQ-022 SHALL never overflow: full queue blocks requests only, never drops bytes.
REQ-023 SHALL, with dec_ready held high and no redirect, sustain one instruction per cycle for 1- and 2-byte streams once primed.

Reset
REQ-024 SHALL on rst: imem_req=0, dec_valid=0, count=0, inflight=0, fetch address=0000, head pc=0000, dec_pc=0000, dec_len=1, dec_instr=000000.
REQ-025 SHALL issue the first request (addr 0000) in the first cycle after rst deasserts; rst mid-operation discards queue and in-flight data immediately.

Structure
REQ-026 SHALL place the opcode-length function, length encodings and instruction-byte field positions in the shared CPU package, reused by decode.
REQ-027 SHALL be a single module; the byte queue MAY be one sub-module named byte_queue (push 2, pop 1-3).

Verification
REQ-028 Reset release, memory 00,00,3E,05 -> req 0000 cycle 1, dec_valid cycle 3 with instr 000000 len1 pc0000, then 000000 pc0001, then 3E0500 len2 pc0002.
REQ-029 Stream C3,34,12 from 0000 -> dec_instr C33412, len3, pc0000; no dec_valid while count<3.
REQ-030 dec_ready low 10 cycles with QDEPTH=8 -> queue reaches 8, imem_req low, outputs stable, no byte lost after release.
REQ-031 redirect to 0100 during an in-flight request -> next-cycle response dropped, next dec_pc 0100 with bytes from 0100.
REQ-032 redirect_pc FFFE, bytes 00,00 then 00 at 0000 -> dec_pc FFFE, FFFF, 0000 in order.
REQ-033 rst asserted while dec_valid high -> dec_valid low same cycle, all outputs at reset values.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// Shared CPU package: instruction length encodings, dec_instr byte field
// positions and the opcode-length / instruction-packing helpers used by both
// fetch alignment and decode.
package fetch_align_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 24;

  // Byte field positions inside the packed {opcode, byte2, byte3} word.
  localparam int INSTR_OP_LSB = 16;
  localparam int INSTR_B2_LSB = 8;
  localparam int INSTR_B3_LSB = 0;

  typedef logic [1:0] ilen_t;
  localparam ilen_t ILEN_1 = 2'd1;
  localparam ilen_t ILEN_2 = 2'd2;
  localparam ilen_t ILEN_3 = 2'd3;

  // Instruction length from the opcode byte alone.
  function automatic ilen_t opcode_len(input logic [7:0] op);
    ilen_t len;
    len = ILEN_1;
    if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) begin
      len = ILEN_3;                                   // LXI rp
    end else if (op == 8'h22 || op == 8'h2A || op == 8'h32 || op == 8'h3A ||
                 op == 8'hC3 || op == 8'hCD) begin
      len = ILEN_3;                                   // SHLD/LHLD/STA/LDA/JMP/CALL
    end else if (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) begin
      len = ILEN_3;                                   // Jccc / Cccc
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) begin
      len = ILEN_2;                                   // MVI
    end else if (op[7:6] == 2'b11 && op[2:0] == 3'b110) begin
      len = ILEN_2;                                   // ALU immediate C6..FE
    end else if (op == 8'hD3 || op == 8'hDB) begin
      len = ILEN_2;                                   // OUT / IN
    end
    return len;
  endfunction

  // Pack instruction bytes, zeroing bytes beyond the instruction length.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [7:0] op,
                                                    input logic [7:0] b2,
                                                    input logic [7:0] b3,
                                                    input ilen_t      len);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[INSTR_OP_LSB +: 8] = op;
    if (len >= ILEN_2) w[INSTR_B2_LSB +: 8] = b2;
    if (len == ILEN_3) w[INSTR_B3_LSB +: 8] = b3;
    return w;
  endfunction

endpackage

// File: rtl/fetch_align_byte_queue.sv
// byte_queue: circular byte FIFO, pushes exactly 2 bytes, pops 1-3 bytes.
// Ports: clk/rst, flush_i, push_i/push_dat_i ([15:8] enters first),
//        pop_i/pop_len_i, count_o, peek0_o..peek2_o (head, head+1, head+2).
module byte_queue
  import fetch_align_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [15:0]   push_dat_i,
  input  logic          pop_i,
  input  ilen_t         pop_len_i,
  output logic [CW-1:0] count_o,
  output logic [7:0]    peek0_o,
  output logic [7:0]    peek1_o,
  output logic [7:0]    peek2_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, k};
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        tail_d  = wrap_add(tail_q, 2'd2);
        count_d = count_d + CW'(2);
      end
      if (pop_i) begin
        head_d  = wrap_add(head_q, pop_len_i);
        count_d = count_d - CW'(pop_len_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !flush_i) begin
        mem_q[tail_q]                 <= push_dat_i[15:8];
        mem_q[wrap_add(tail_q, 2'd1)] <= push_dat_i[7:0];
      end
    end
  end

  assign count_o = count_q;
  assign peek0_o = mem_q[head_q];
  assign peek1_o = mem_q[wrap_add(head_q, 2'd1)];
  assign peek2_o = mem_q[wrap_add(head_q, 2'd2)];

endmodule

// File: rtl/fetch_align.sv
// fetch_align: turns a 16-bit instruction-memory word stream into aligned
// 1-3 byte instructions for decode, with flush-and-refetch on redirect.
// Ports: clk/rst; imem_req/imem_addr out, imem_rdata in (one-cycle latency);
//        redirect/redirect_pc in; dec_valid/dec_instr/dec_len/dec_pc out, dec_ready in.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [1:0]         dec_len,
  output logic [ADDR_W-1:0]  dec_pc
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              inflight_q, inflight_d;   // a response arrives this cycle
  logic              redir_q, redir_d;         // previous cycle was a redirect

  logic [CW-1:0] q_count;
  logic [7:0]    q_b0, q_b1, q_b2;
  logic [31:0]   need;
  logic          room;
  logic          xfer;
  logic          push;

  byte_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (imem_rdata),
    .pop_i      (xfer),
    .pop_len_i  (dec_len),
    .count_o    (q_count),
    .peek0_o    (q_b0),
    .peek1_o    (q_b1),
    .peek2_o    (q_b2)
  );

  // Reserve space for the response already on its way plus the new one,
  // so a full queue only ever stalls requests and never drops bytes.
  always_comb begin
    need = 32'(q_count) + (inflight_q ? 32'd4 : 32'd2);
    room = (need <= 32'(QDEPTH));
  end

  assign imem_req  = !rst && !redirect && room;
  assign imem_addr = fetch_q;

  assign dec_len   = opcode_len(q_b0);
  assign dec_valid = !rst && !redir_q && (q_count >= CW'(dec_len));
  assign dec_instr = pack_instr(q_b0, q_b1, q_b2, dec_len);
  assign dec_pc    = head_pc_q;

  // Redirect overrides both the transfer and the push of a returning word.
  assign xfer = dec_valid && dec_ready && !redirect;
  assign push = inflight_q && !redirect;

  always_comb begin
    fetch_d    = fetch_q;
    head_pc_d  = head_pc_q;
    inflight_d = imem_req;
    redir_d    = redirect;
    if (redirect) begin
      fetch_d   = redirect_pc;
      head_pc_d = redirect_pc;
    end else begin
      if (imem_req) fetch_d   = fetch_q + 16'd2;
      if (xfer)     head_pc_d = head_pc_q + 16'(dec_len);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q    <= '0;
      head_pc_q  <= '0;
      inflight_q <= 1'b0;
      redir_q    <= 1'b0;
    end else begin
      fetch_q    <= fetch_d;
      head_pc_q  <= head_pc_d;
      inflight_q <= inflight_d;
      redir_q    <= redir_d;
    end
  end

endmodule
